// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with signed coordinates
module vga_timing_gen #(
    parameter int CORDW    = 16,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CLK_DIV  = 1,
    parameter int FCW      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enb,
    output logic                    pix_tick,
    output logic signed [CORDW-1:0] x,
    output logic signed [CORDW-1:0] y,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic                    line_start,
    output logic                    frame_start,
    output logic [FCW-1:0]          frame_cnt
);

    // Blanking lives at negative coordinates: front porch, sync, back porch, then x/y = 0.
    localparam logic signed [CORDW-1:0] H_STA  = CORDW'(-(H_FP + H_SYNC + H_BP));
    localparam logic signed [CORDW-1:0] H_END  = CORDW'(H_ACTIVE - 1);
    localparam logic signed [CORDW-1:0] HS_BEG = CORDW'(-(H_SYNC + H_BP));
    localparam logic signed [CORDW-1:0] HS_FIN = CORDW'(-H_BP - 1);
    localparam logic signed [CORDW-1:0] V_STA  = CORDW'(-(V_FP + V_SYNC + V_BP));
    localparam logic signed [CORDW-1:0] V_END  = CORDW'(V_ACTIVE - 1);
    localparam logic signed [CORDW-1:0] VS_BEG = CORDW'(-(V_SYNC + V_BP));
    localparam logic signed [CORDW-1:0] VS_FIN = CORDW'(-V_BP - 1);
    localparam logic signed [CORDW-1:0] ONE    = CORDW'(1);
    localparam logic signed [CORDW-1:0] ZERO   = CORDW'(0);

    localparam logic HS_ON  = (H_POL != 0);
    localparam logic VS_ON  = (V_POL != 0);

    localparam int              DIVW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);

    logic [DIVW-1:0]         div_cnt;
    logic                    tick;
    logic signed [CORDW-1:0] x_nxt;
    logic signed [CORDW-1:0] y_nxt;
    logic                    in_hs;
    logic                    in_vs;
    logic                    active_nxt;
    logic                    line_nxt;
    logic                    frame_nxt;

    // Outputs are decoded from the next-state counters so they line up with x/y.
    always_comb begin
        tick  = enb && (div_cnt == DIV_LAST);
        x_nxt = x + ONE;
        y_nxt = y;
        if (x == H_END) begin
            x_nxt = H_STA;
            y_nxt = (y == V_END) ? V_STA : y + ONE;
        end
        in_hs      = (x_nxt >= HS_BEG) && (x_nxt <= HS_FIN);
        in_vs      = (y_nxt >= VS_BEG) && (y_nxt <= VS_FIN);
        active_nxt = !x_nxt[CORDW-1] && !y_nxt[CORDW-1];
        line_nxt   = (x_nxt == ZERO) && !y_nxt[CORDW-1];
        frame_nxt  = (x_nxt == ZERO) && (y_nxt == ZERO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            x           <= H_STA;
            y           <= V_STA;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            pix_tick    <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            pix_tick    <= tick;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            // A low enb freezes the divider mid-count so resuming finishes the partial pixel.
            if (enb) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
            end
            if (tick) begin
                x           <= x_nxt;
                y           <= y_nxt;
                hsync       <= in_hs ? HS_ON : ~HS_ON;
                vsync       <= in_vs ? VS_ON : ~VS_ON;
                de          <= active_nxt;
                line_start  <= line_nxt;
                frame_start <= frame_nxt;
                if (frame_nxt) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen in a 14x8 px mode
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enb = 1'b0;

    logic               pix_tick, hsync, vsync, de, line_start, frame_start;
    logic signed [15:0] x, y;
    logic [1:0]         frame_cnt;

    logic               pix_tick_p, hsync_p, vsync_p, de_p, line_start_p, frame_start_p;
    logic signed [15:0] x_p, y_p;
    logic [1:0]         frame_cnt_p;

    int vectors = 0;
    int miscompares = 0;

    // Bench model: clocks since reset with enb high, ticks, frames started.
    int c_m = 0;
    int n_m = 0;
    int fc_m = 0;
    int x_m = -6;
    int y_m = -4;
    logic tick_m = 1'b0;
    logic ls_m = 1'b0;
    logic fs_m = 1'b0;

    int de_pix = 0;
    int ls_cnt = 0;
    int fs_cnt = 0;
    int k;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CORDW(16), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(0), .V_POL(0), .CLK_DIV(2), .FCW(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enb(enb), .pix_tick(pix_tick),
        .x(x), .y(y), .hsync(hsync), .vsync(vsync), .de(de),
        .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    vga_timing_gen #(
        .CORDW(16), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1), .V_POL(1), .CLK_DIV(2), .FCW(2)
    ) dut_pos (
        .clk(clk), .rst_n(rst_n), .enb(enb), .pix_tick(pix_tick_p),
        .x(x_p), .y(y_p), .hsync(hsync_p), .vsync(vsync_p), .de(de_p),
        .line_start(line_start_p), .frame_start(frame_start_p), .frame_cnt(frame_cnt_p)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic e);
        int pos;
        tick_m = 1'b0;
        ls_m   = 1'b0;
        fs_m   = 1'b0;
        if (!r) begin
            c_m  = 0;
            n_m  = 0;
            fc_m = 0;
        end else if (e) begin
            c_m++;
            if (c_m % 2 == 0) begin
                tick_m = 1'b1;
                n_m++;
            end
        end
        pos = n_m % 112;
        x_m = -6 + pos % 14;
        y_m = -4 + pos / 14;
        if (tick_m) begin
            ls_m = (x_m == 0) && (y_m >= 0);
            fs_m = (x_m == 0) && (y_m == 0);
            if (fs_m) fc_m = (fc_m + 1) % 4;
        end
    endtask

    task automatic step(input logic r, input logic e);
        logic hs_on, vs_on;
        rst_n = r;
        enb   = e;
        @(posedge clk);
        model_update(r, e);
        @(negedge clk);
        hs_on = (x_m >= -4) && (x_m <= -2);
        vs_on = (y_m >= -3) && (y_m <= -2);
        chk("x", x, x_m);
        chk("y", y, y_m);
        chk("pix_tick", pix_tick, tick_m);
        chk("hsync", hsync, !hs_on);
        chk("vsync", vsync, !vs_on);
        chk("de", de, (x_m >= 0) && (y_m >= 0));
        chk("line_start", line_start, ls_m);
        chk("frame_start", frame_start, fs_m);
        chk("frame_cnt", frame_cnt, fc_m);
        chk("hsync_pos", hsync_p, hs_on);
        chk("vsync_pos", vsync_p, vs_on);
    endtask

    initial begin
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("rst_x", x, -6);
        chk("rst_y", y, -4);
        chk("rst_frame_cnt", frame_cnt, 0);

        // Two full frames (224 ticks), tallying strobes, then two more to roll FCW=2 over.
        for (int i = 0; i < 900; i++) begin
            step(1'b1, 1'b1);
            if (i < 448) begin
                if (pix_tick && de) de_pix++;
                if (line_start) ls_cnt++;
                if (frame_start) fs_cnt++;
            end
            if (c_m == 224) begin
                chk("wrap_x", x, -6);
                chk("wrap_y", y, -4);
                chk("wrap_de", de, 0);
            end
            if (c_m == 448) chk("two_frames_cnt", frame_cnt, 2);
            if (c_m == 796) chk("fcw_rollover", frame_cnt, 0);
        end
        chk("de_pixels_2frames", de_pix, 64);
        chk("line_starts_2frames", ls_cnt, 8);
        chk("frame_starts_2frames", fs_cnt, 2);

        k = 0;
        while (!(x_m == 3 && (c_m % 2 == 1)) && k < 500) begin
            step(1'b1, 1'b1);
            k++;
        end
        chk("reach_x3_bound", k < 500, 1);
        repeat (5) step(1'b1, 1'b0);
        chk("hold_x", x, 3);
        step(1'b1, 1'b1);
        chk("resume_tick", pix_tick, 1);
        chk("resume_x", x, 4);

        k = 0;
        while (!(x_m == 5 && y_m == 2) && k < 500) begin
            step(1'b1, 1'b1);
            k++;
        end
        chk("reach_x5y2_bound", k < 500, 1);
        step(1'b0, 1'b1);
        chk("midrst_x", x, -6);
        chk("midrst_y", y, -4);
        chk("midrst_frame_cnt", frame_cnt, 0);

        k = 0;
        while (k < 300) begin
            step(1'b1, 1'b1);
            k++;
            if (frame_start) break;
        end
        chk("first_fs_clks", k, 124);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It produces signed pixel/line coordinates, sync pulses of selectable polarity, and a data-enable signal, plus frame/line strobes and a frame counter. Blanking occupies negative coordinates and the active area is x,y ≥ 0, so sprite and game logic index screen space directly. It sits between the board clock/PLL and the pixel pipeline, and supports any VESA-style mode through parameters plus an internal pixel-clock divider.

## Interface
Parameters:
- CORDW, 16: signed coordinate width; must hold −(H_FP+H_SYNC+H_BP) and H_ACTIVE−1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- H_POL, 0: hsync asserted level (0 = active-low).
- V_POL, 0: vsync asserted level (0 = active-low).
- CLK_DIV, 1: clk cycles per pixel; must be ≥ 1.
- FCW, 16: frame counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- enb  in  1  run enable; when low, counters, divider and outputs hold.
- pix_tick  out  1  one-clk pulse per pixel advance.
- x  out  CORDW  signed pixel coordinate.
- y  out  CORDW  signed line coordinate.
- hsync  out  1  horizontal sync, level set by H_POL.
- vsync  out  1  vertical sync, level set by V_POL.
- de  out  1  data enable, high when x ≥ 0 and y ≥ 0.
- line_start  out  1  one-clk pulse when an active line begins.
- frame_start  out  1  one-clk pulse when pixel (0,0) is entered.
- frame_cnt  out  FCW  completed-frame counter, wraps.

## Operation
- Derived constants:
  - H_STA = −(H_FP+H_SYNC+H_BP), H_END = H_ACTIVE−1.
  - V_STA = −(V_FP+V_SYNC+V_BP), V_END = V_ACTIVE−1.
- Divider: div_cnt runs 0..CLK_DIV−1 while enb=1. A tick occurs when enb=1 and div_cnt=CLK_DIV−1. With CLK_DIV=1, tick = enb.
- On a tick:
  - If x=H_END: x←H_STA. Then if y=V_END: y←V_STA, else y←y+1.
  - Otherwise: x←x+1.
- Blanking order inside the negative region is front porch, sync, back porch.
  - hsync is asserted for x ∈ [H_STA+H_FP, H_STA+H_FP+H_SYNC−1].
  - vsync is asserted for y ∈ [V_STA+V_FP, V_STA+V_FP+V_SYNC−1].
- All outputs are registered and decoded from the next-state counters, so hsync, vsync, de and the strobes always match the x/y values in the same cycle.
- line_start: pulses in the cycle after a tick moves x to 0 while y ≥ 0.
- frame_start: pulses in the cycle after a tick moves (x,y) to (0,0). frame_start implies line_start.
- frame_cnt increments in the same cycle frame_start rises. It wraps modulo 2^FCW.
- Arithmetic is signed CORDW throughout. No overflow is possible for legal parameters.

## Timing
- Reset values (the cycle after rst_n is sampled low):
  - x=H_STA, y=V_STA, div_cnt=0, frame_cnt=0.
  - hsync=~H_POL, vsync=~V_POL.
  - de=0, line_start=0, frame_start=0, pix_tick=0.
- Reset mid-frame aborts immediately. The next tick after release moves to x=H_STA+1.
- Latency: x, y, de, syncs and strobes change on the clk edge following the tick condition. pix_tick is high in that same cycle.
- enb low: div_cnt freezes (it does not clear). Resuming continues the partial divide. Strobes are 0 while held.
- Timing per frame:
  - Line period = (H_ACTIVE+H_FP+H_SYNC+H_BP) ticks.
  - Frame period = line period × (V_ACTIVE+V_FP+V_SYNC+V_BP).
  - Clk cycles per frame = frame period × CLK_DIV.
- Simultaneous line and frame wrap (x=H_END, y=V_END): a single tick resets both. No intermediate y value appears.
- rst_n has priority over enb.

## Test plan
Small mode used throughout: H 8/2/3/1, V 4/1/2/1, CLK_DIV=2, so H_STA=−6, V_STA=−4, 14 px/line, 112 ticks/frame.

- Reset, then enb=1 held: x=−6, y=−4 after reset. pix_tick occurs every 2nd clk. x counts −6..7 then wraps to −6 with y+1. y wraps 3→−4 after 224 clk.
- Sync windows, active-low: hsync=0 exactly for x ∈ {−4,−3,−2}; vsync=0 exactly for y ∈ {−3,−2}. Repeat with H_POL=V_POL=1 and expect inverted levels.
- de/strobes: de=1 for exactly 32 pixels per frame. line_start fires 4 times per frame. frame_start fires once, coincident with x=0, y=0. frame_cnt goes 0→1→2 over two frames.
- enb toggled low for 5 clk mid-line at x=3 with div_cnt=1: all outputs hold. The next tick arrives 1 clk after enb returns high, and x becomes 4.
- rst_n pulsed low at x=5, y=2: outputs return to reset values next cycle. frame_cnt=0. The first frame_start occurs 112×2 clk later, minus the initial offset.
- Wrap corner: at x=7, y=3, the next tick gives x=−6, y=−4, de=0. The following frame_start and frame_cnt FCW rollover are checked with FCW=2: 3→0.
